// File: rtl/immgen_pkg.sv
// Shared definitions for the registered immediate generator: format codes and major opcodes (instr[6:2]).
package immgen_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

endpackage

// File: rtl/immgen_if.sv
// Fetch-to-decode handshake bundle for immgen_pipe; slave is the pipe, master is the upstream/downstream side.
interface immgen_if #(
  parameter int unsigned XLEN = 32
) ();
  import immgen_pkg::*;

  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instruction_i;
  logic [XLEN-1:0] pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] immediate_o;
  fmt_e            fmt_o;
  logic [XLEN-1:0] target_o;
  logic            illegal_o;

  modport master (
    output flush_i, in_valid_i, instruction_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, immediate_o, fmt_o, target_o, illegal_o
  );

  modport slave (
    input  flush_i, in_valid_i, instruction_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, immediate_o, fmt_o, target_o, illegal_o
  );
endinterface

// File: rtl/immgen_decode.sv
// Combinational RV32/RV64 immediate decoder: (instruction, pc) -> (imm, fmt, pc+imm, illegal).
// Optional IMMGEN_ZICSR_EN: SYSTEM decodes as FMT_Z with a zero-extended instr[19:15] immediate.
module immgen_decode
  import immgen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);

  logic [4:0]        opc;
  logic              s;
  logic signed [31:0] imm32;

  assign opc = instruction_i[6:2];
  assign s   = instruction_i[31];

  // Every format is first built as a signed 32-bit value, then sign-extended once to XLEN.
  always_comb begin
    imm32     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    if (instruction_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (opc)
        OPC_OP: fmt_o = FMT_R;
        OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
          fmt_o = FMT_I;
          imm32 = {{20{s}}, instruction_i[31:20]};
        end
        OPC_STORE: begin
          fmt_o = FMT_S;
          imm32 = {{20{s}}, instruction_i[31:25], instruction_i[11:7]};
        end
        OPC_BRANCH: begin
          fmt_o = FMT_B;
          imm32 = {{19{s}}, s, instruction_i[7], instruction_i[30:25],
                   instruction_i[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt_o = FMT_U;
          imm32 = {instruction_i[31:12], 12'h000};
        end
        OPC_JAL: begin
          fmt_o = FMT_J;
          imm32 = {{11{s}}, s, instruction_i[19:12], instruction_i[20],
                   instruction_i[30:21], 1'b0};
        end
`ifdef IMMGEN_ZICSR_EN
        OPC_SYSTEM: begin
          fmt_o = FMT_Z;
          imm32 = {27'd0, instruction_i[19:15]};
        end
`endif
        default: illegal_o = 1'b1;
      endcase
    end
  end

  assign imm_o    = XLEN'(imm32);
  assign target_o = pc_i + imm_o;

endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator with a 2-entry (main + skid) valid/ready buffer between fetch and decode.
// Build option IMMGEN_ZICSR_EN enables FMT_Z decoding of SYSTEM instructions (see immgen_decode).
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  immgen_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    fmt_e            fmt;
    logic            ill;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: '0, tgt: '0, fmt: FMT_NONE, ill: 1'b0};

  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  entry_t          dec;
  logic [XLEN-1:0] dec_imm, dec_tgt;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic            accept, emit;

  immgen_decode #(.XLEN(XLEN)) u_decode (
    .instruction_i (bus.instruction_i),
    .pc_i          (bus.pc_i),
    .imm_o         (dec_imm),
    .fmt_o         (dec_fmt),
    .target_o      (dec_tgt),
    .illegal_o     (dec_ill)
  );

  assign dec    = '{imm: dec_imm, tgt: dec_tgt, fmt: dec_fmt, ill: dec_ill};
  assign accept = bus.in_valid_i & ~skid_valid_q;
  assign emit   = main_valid_q & bus.out_ready_i;

  // Skid valid implies in_ready low, so a skid refill and a new accept never coincide.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (bus.flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || emit) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= ENTRY_RST;
      skid_q       <= ENTRY_RST;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.in_ready_o  = ~skid_valid_q;
  assign bus.out_valid_o = main_valid_q;
  assign bus.immediate_o = main_q.imm;
  assign bus.fmt_o       = main_q.fmt;
  assign bus.target_o    = main_q.tgt;
  assign bus.illegal_o   = main_q.ill;

endmodule
